// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: shares the register-file write port between the in-order
// WB stage and an out-of-order MUL/DIV unit. MUL/DIV results are buffered in a
// small FIFO and drained into free port cycles. If the FIFO head keeps losing,
// the pipeline is stalled for one cycle. A scoreboard tracks pending MUL/DIV
// destinations for the hazard unit.
module reg_write_arbiter #(
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        PIPE_WE,
  input  logic [4:0]  PIPE_ADDR,
  input  logic [31:0] PIPE_DATA,
  output logic        PIPE_STALL,
  input  logic        MD_ISSUE,
  input  logic [4:0]  MD_ISSUE_RD,
  input  logic        MD_VALID,
  input  logic [4:0]  MD_ADDR,
  input  logic [31:0] MD_DATA,
  output logic        MD_READY,
  output logic [31:0] BUSY,
  output logic        WRITE_ENABLE,
  output logic [4:0]  WRITE_ADDRESS,
  output logic [31:0] WRITE_DATA
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    r_fifo_addr [FIFO_DEPTH];
  logic [31:0]   r_fifo_data [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_starve;
  logic          r_stall;
  logic [31:0]   r_busy;

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_pipe_req;
  logic          w_fifo_win;
  logic          w_pipe_win;
  logic [4:0]    w_head_addr;
  logic [31:0]   w_head_data;
  logic [31:0]   w_set;
  logic [31:0]   w_clr;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_head_addr = r_fifo_addr[r_rptr];
  assign w_head_data = r_fifo_data[r_rptr];

  // Pipeline requests are masked during reset so the port is idle immediately.
  assign w_pipe_req  = PIPE_WE && (PIPE_ADDR != 5'd0) && !RESET;
  // During a stall cycle the FIFO head owns the port regardless of PIPE_WE.
  assign w_fifo_win  = !w_empty && (r_stall || !w_pipe_req);
  assign w_pipe_win  = w_pipe_req && !w_fifo_win;
  assign w_pop       = w_fifo_win;
  // x0 results complete the handshake but are dropped.
  assign w_push      = MD_VALID && !w_full && (MD_ADDR != 5'd0);

  assign MD_READY    = !w_full;
  assign PIPE_STALL  = r_stall;
  assign BUSY        = r_busy;

  // Write-port mux: route the arbitration winner to the register file.
  always_comb begin
    WRITE_ENABLE  = 1'b0;
    WRITE_ADDRESS = '0;
    WRITE_DATA    = '0;
    if (w_fifo_win) begin
      WRITE_ENABLE  = 1'b1;
      WRITE_ADDRESS = w_head_addr;
      WRITE_DATA    = w_head_data;
    end else if (w_pipe_win) begin
      WRITE_ENABLE  = 1'b1;
      WRITE_ADDRESS = PIPE_ADDR;
      WRITE_DATA    = PIPE_DATA;
    end
  end

  // Scoreboard set/clear vectors for this cycle.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (MD_ISSUE && (MD_ISSUE_RD != 5'd0)) w_set[MD_ISSUE_RD] = 1'b1;
    if (w_pop)                              w_clr[w_head_addr] = 1'b1;
  end

  // FIFO storage: contents need no reset, validity comes from r_count.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_fifo_addr[r_wptr] <= MD_ADDR;
      r_fifo_data[r_wptr] <= MD_DATA;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Pending-write scoreboard; a same-cycle set overrides a clear.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_busy <= '0;
    end else begin
      r_busy <= ((r_busy & ~w_clr) | w_set) & 32'hFFFF_FFFE;
    end
  end

  // Starvation counter and one-cycle pipeline stall.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else begin
      if (w_empty || w_pop) begin
        r_starve <= '0;
      end else if (r_starve != SW'(STARVE_LIMIT)) begin
        r_starve <= r_starve + SW'(1);
      end
      r_stall <= !w_empty && !w_pop && !r_stall &&
                 (r_starve == SW'(STARVE_LIMIT - 1));
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios followed by constrained
// random traffic, all checked against a queue-based behavioural model.
module tb_reg_write_arbiter;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned LIMIT = 4;

  logic        CLK;
  logic        RESET;
  logic        PIPE_WE;
  logic [4:0]  PIPE_ADDR;
  logic [31:0] PIPE_DATA;
  logic        PIPE_STALL;
  logic        MD_ISSUE;
  logic [4:0]  MD_ISSUE_RD;
  logic        MD_VALID;
  logic [4:0]  MD_ADDR;
  logic [31:0] MD_DATA;
  logic        MD_READY;
  logic [31:0] BUSY;
  logic        WRITE_ENABLE;
  logic [4:0]  WRITE_ADDRESS;
  logic [31:0] WRITE_DATA;

  reg_write_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .RESET(RESET),
    .PIPE_WE(PIPE_WE), .PIPE_ADDR(PIPE_ADDR), .PIPE_DATA(PIPE_DATA),
    .PIPE_STALL(PIPE_STALL),
    .MD_ISSUE(MD_ISSUE), .MD_ISSUE_RD(MD_ISSUE_RD),
    .MD_VALID(MD_VALID), .MD_ADDR(MD_ADDR), .MD_DATA(MD_DATA),
    .MD_READY(MD_READY), .BUSY(BUSY),
    .WRITE_ENABLE(WRITE_ENABLE), .WRITE_ADDRESS(WRITE_ADDRESS),
    .WRITE_DATA(WRITE_DATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural model: FIFO as a queue of {addr,data}, busy bitmap,
  // consecutive-loss count and pending stall flag.
  logic [36:0]  q[$];
  logic [31:0]  m_busy;
  int unsigned  m_loss;
  bit           m_stall;

  int total = 0;
  int bad   = 0;

  // Values captured during the last step.
  logic        g_we;
  logic [4:0]  g_addr;
  logic [31:0] g_data;
  logic        g_dut_stall;
  bit          g_hs;
  bit          g_stall_pre;

  // Random-phase stimulus state.
  logic [4:0]  outst[$];
  bit          md_active;
  logic [4:0]  md_cur;
  logic [31:0] md_dat;
  int unsigned stall_cnt;
  int unsigned md_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_busy  = '0;
    m_loss  = 0;
    m_stall = 0;
  endtask

  task automatic set_idle();
    PIPE_WE = 0; PIPE_ADDR = '0; PIPE_DATA = '0;
    MD_ISSUE = 0; MD_ISSUE_RD = '0;
    MD_VALID = 0; MD_ADDR = '0; MD_DATA = '0;
  endtask

  // One clock cycle: check outputs against the model, then advance both.
  task automatic step();
    bit          empty, preq, fw, pw, nstall;
    logic        ew;
    logic [4:0]  ea;
    logic [31:0] ed;
    #1;
    g_we = WRITE_ENABLE; g_addr = WRITE_ADDRESS; g_data = WRITE_DATA;
    g_dut_stall = PIPE_STALL;
    empty = (q.size() == 0);
    preq  = PIPE_WE && (PIPE_ADDR != 0);
    fw    = !empty && (m_stall || !preq);
    pw    = preq && !fw;
    ew = 0; ea = '0; ed = '0;
    if (fw) begin
      ew = 1; ea = q[0][36:32]; ed = q[0][31:0];
    end else if (pw) begin
      ew = 1; ea = PIPE_ADDR; ed = PIPE_DATA;
    end
    g_hs        = MD_VALID && (q.size() < DEPTH);
    g_stall_pre = m_stall;
    chk("wr_en",    {31'd0, WRITE_ENABLE}, {31'd0, ew});
    chk("wr_addr",  {27'd0, WRITE_ADDRESS}, {27'd0, ea});
    chk("wr_data",  WRITE_DATA, ed);
    chk("md_ready", {31'd0, MD_READY}, {31'd0, (q.size() < DEPTH)});
    chk("busy",     BUSY, m_busy);
    chk("stall",    {31'd0, PIPE_STALL}, {31'd0, m_stall});
    nstall = !empty && !fw && (m_loss + 1 == LIMIT);
    m_loss = (empty || fw) ? 0 : m_loss + 1;
    if (fw) begin
      m_busy[q[0][36:32]] = 1'b0;
      void'(q.pop_front());
    end
    if (MD_ISSUE && MD_ISSUE_RD != 0) m_busy[MD_ISSUE_RD] = 1'b1;
    if (g_hs && MD_ADDR != 0) q.push_back({MD_ADDR, MD_DATA});
    m_stall = nstall;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task automatic async_reset();
    #2;
    RESET = 1;
    #1;
    chk("rst_we",    {31'd0, WRITE_ENABLE}, 32'd0);
    chk("rst_addr",  {27'd0, WRITE_ADDRESS}, 32'd0);
    chk("rst_data",  WRITE_DATA, 32'd0);
    chk("rst_busy",  BUSY, 32'd0);
    chk("rst_stall", {31'd0, PIPE_STALL}, 32'd0);
    chk("rst_ready", {31'd0, MD_READY}, 32'd1);
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    RESET = 0;
  endtask

  function automatic logic [4:0] pick_free(input logic [4:0] excl);
    logic [4:0] a;
    for (int unsigned t = 0; t < 64; t++) begin
      a = 5'($urandom_range(31, 1));
      if (!m_busy[a] && a != excl) return a;
    end
    return 5'd0;
  endfunction

  initial begin
    set_idle();
    RESET = 1;
    model_reset();
    md_active = 0; md_cur = '0; md_dat = '0;
    @(negedge CLK);
    chk("init_we",    {31'd0, WRITE_ENABLE}, 32'd0);
    chk("init_busy",  BUSY, 32'd0);
    chk("init_ready", {31'd0, MD_READY}, 32'd1);
    RESET = 0;

    // Pipeline write passes straight through.
    PIPE_WE = 1; PIPE_ADDR = 5'd1; PIPE_DATA = 32'd5;
    step();
    chk("t1_we",   {31'd0, g_we}, 32'd1);
    chk("t1_addr", {27'd0, g_addr}, 32'd1);
    chk("t1_data", g_data, 32'd5);
    // Buffer a result for x9, then reset while it is pending.
    PIPE_WE = 0; MD_ISSUE = 1; MD_ISSUE_RD = 5'd9;
    step();
    MD_ISSUE = 0; PIPE_WE = 1;
    MD_VALID = 1; MD_ADDR = 5'd9; MD_DATA = 32'hAAAA_0009;
    step();
    MD_VALID = 0;
    chk("t1_busy9", {31'd0, BUSY[9]}, 32'd1);
    async_reset();
    set_idle();
    step();
    step();

    // Issue, return, write-back of x3.
    MD_ISSUE = 1; MD_ISSUE_RD = 5'd3;
    step();
    MD_ISSUE = 0;
    chk("t2_busy3_set", {31'd0, BUSY[3]}, 32'd1);
    step();
    MD_VALID = 1; MD_ADDR = 5'd3; MD_DATA = 32'h1234_5678;
    step();
    MD_VALID = 0;
    step();
    chk("t2_wr_addr", {27'd0, g_addr}, 32'd3);
    chk("t2_wr_data", g_data, 32'h1234_5678);
    step();
    chk("t2_busy3_clr", {31'd0, BUSY[3]}, 32'd0);

    // Starvation: pipeline writes every cycle while x4, x5 wait.
    MD_ISSUE = 1; MD_ISSUE_RD = 5'd4; step();
    MD_ISSUE_RD = 5'd5; step();
    MD_ISSUE = 0;
    PIPE_WE = 1; PIPE_ADDR = 5'd10; PIPE_DATA = 32'h0000_00AB;
    MD_VALID = 1; MD_ADDR = 5'd4; MD_DATA = 32'h4444_4444; step();
    MD_ADDR = 5'd5; MD_DATA = 32'h5555_5555; step();
    MD_VALID = 0;
    chk("t3_ready_full", {31'd0, MD_READY}, 32'd0);
    stall_cnt = 0;
    for (int unsigned i = 0; i < 11; i++) begin
      step();
      if (g_dut_stall) begin
        chk("t3_stall_wr", {27'd0, g_addr}, (stall_cnt == 0) ? 32'd4 : 32'd5);
        stall_cnt++;
      end
    end
    chk("t3_stall_cnt", stall_cnt, 32'd2);
    set_idle();
    step();

    // x0 pipeline write frees the port; x0 MD result is dropped.
    MD_ISSUE = 1; MD_ISSUE_RD = 5'd6; step();
    MD_ISSUE = 0;
    PIPE_WE = 1; PIPE_ADDR = 5'd10; PIPE_DATA = 32'd1;
    MD_VALID = 1; MD_ADDR = 5'd6; MD_DATA = 32'h6666_0006; step();
    MD_VALID = 0;
    PIPE_ADDR = 5'd0; PIPE_DATA = 32'd10; step();
    chk("t4_wr_addr", {27'd0, g_addr}, 32'd6);
    chk("t4_wr_en",   {31'd0, g_we}, 32'd1);
    set_idle();
    MD_VALID = 1; MD_ADDR = 5'd0; MD_DATA = 32'hDEAD_BEEF; step();
    chk("t4_x0_hs", {31'd0, g_hs}, 32'd1);
    MD_VALID = 0;
    step();
    chk("t4_x0_nowr", {31'd0, g_we}, 32'd0);
    step();

    // Fill the FIFO, then stream pops with same-cycle pushes.
    for (int unsigned r = 11; r <= 18; r++) begin
      MD_ISSUE = 1; MD_ISSUE_RD = 5'(r); step();
    end
    MD_ISSUE = 0;
    PIPE_WE = 1; PIPE_ADDR = 5'd25; PIPE_DATA = 32'h2525;
    md_i = 11;
    while (md_i <= 18 && total < 100000) begin
      if (md_i == 13) PIPE_WE = 0;
      MD_VALID = 1; MD_ADDR = 5'(md_i); MD_DATA = 32'hF000_0000 + md_i;
      step();
      if (g_hs) md_i++;
    end
    set_idle();
    repeat (4) step();
    chk("t5_drained", BUSY, 32'd0);

    // Issue to x7 in the cycle x7 is popped: set wins.
    MD_ISSUE = 1; MD_ISSUE_RD = 5'd7; step();
    MD_ISSUE = 0;
    MD_VALID = 1; MD_ADDR = 5'd7; MD_DATA = 32'h7777_0001; step();
    MD_VALID = 0;
    MD_ISSUE = 1; MD_ISSUE_RD = 5'd7; step();
    MD_ISSUE = 0;
    chk("t6_pop_addr", {27'd0, g_addr}, 32'd7);
    step();
    chk("t6_busy7", {31'd0, BUSY[7]}, 32'd1);
    MD_VALID = 1; MD_ADDR = 5'd7; MD_DATA = 32'h7777_0002; step();
    MD_VALID = 0;
    step();
    step();

    // Random traffic obeying the hazard-unit protocol.
    set_idle();
    outst.delete();
    md_active = 0;
    g_stall_pre = 0;
    for (int unsigned i = 0; i < 400; i++) begin
      if (i == 200) begin
        async_reset();
        outst.delete();
        md_active = 0;
        g_stall_pre = 0;
        set_idle();
      end
      if (!g_stall_pre) begin
        PIPE_WE   = ($urandom_range(0, 3) != 0);
        PIPE_ADDR = ($urandom_range(0, 7) == 0) ? 5'd0 : pick_free(5'd0);
        PIPE_DATA = $urandom;
      end
      MD_ISSUE    = ($urandom_range(0, 2) == 0);
      MD_ISSUE_RD = ($urandom_range(0, 7) == 0) ? 5'd0 : pick_free(PIPE_ADDR);
      if (!md_active && $urandom_range(0, 1) == 1) begin
        if (outst.size() > 0) begin
          int k;
          k = $urandom_range(0, outst.size() - 1);
          md_cur = outst[k];
          outst.delete(k);
          md_active = 1;
          md_dat = $urandom;
        end else if ($urandom_range(0, 3) == 0) begin
          md_cur = 5'd0;
          md_active = 1;
          md_dat = $urandom;
        end
      end
      MD_VALID = md_active;
      MD_ADDR  = md_active ? md_cur : 5'd0;
      MD_DATA  = md_active ? md_dat : 32'd0;
      step();
      if (md_active && g_hs) md_active = 0;
      if (MD_ISSUE && MD_ISSUE_RD != 0) outst.push_back(MD_ISSUE_RD);
    end
    set_idle();
    repeat (6) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
